muldiv_unit: RTL

- Iterative RV32M-style multiply/divide unit, parametrised in operand width.
- Sits beside the single-cycle ALU and executes the M-extension ops the ALU lacks: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Requests and responses use valid/ready handshakes, so the core stalls issue while the unit is busy.
- Computes one result bit per cycle (shift-add multiply, restoring divide), with single-cycle fast paths for the divide special cases.

---
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// =============================================================================
// muldiv_unit : iterative RV32M multiply/divide, one result bit per cycle
// Rev 1.0
// =============================================================================
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      req_op_i,
   input  logic [XLEN-1:0] req_a_i,
   input  logic [XLEN-1:0] req_b_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] resp_result_o,
   output logic            busy_o
);

   localparam int CNT_W = $clog2(XLEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                negres_q, negres_d;
   logic                negrem_q, negrem_d;
   logic                special_q, special_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                w_a_signed, w_b_signed, w_sa, w_sb;
   logic [XLEN-1:0]     w_abs_a, w_abs_b;
   logic                w_div0, w_ovf, w_special;
   logic [XLEN-1:0]     w_special_res;
   logic [XLEN:0]       w_mul_add, w_div_r, w_div_diff;
   logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_prod_fix;
   logic [XLEN-1:0]     w_quo_fix, w_rem_fix, w_fix_res;

   // Operand sign handling at accept
   assign w_a_signed = (req_op_i == 3'd1) || (req_op_i == 3'd2) ||
                       (req_op_i == 3'd4) || (req_op_i == 3'd6);
   assign w_b_signed = (req_op_i == 3'd1) || (req_op_i == 3'd4) || (req_op_i == 3'd6);
   assign w_sa       = w_a_signed & req_a_i[XLEN-1];
   assign w_sb       = w_b_signed & req_b_i[XLEN-1];
   assign w_abs_a    = w_sa ? (-req_a_i) : req_a_i;
   assign w_abs_b    = w_sb ? (-req_b_i) : req_b_i;

   assign w_div0     = req_op_i[2] && (req_b_i == '0);
   assign w_ovf      = ((req_op_i == 3'd4) || (req_op_i == 3'd6)) &&
                       (req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&req_b_i);
   assign w_special  = w_div0 || w_ovf;
   assign w_special_res = w_div0 ? (req_op_i[1] ? req_a_i : {XLEN{1'b1}})
                                 : (req_op_i[1] ? {XLEN{1'b0}} : req_a_i);

   // Shift-add multiply: multiplier lives in the low half and shifts out as the product grows
   assign w_mul_add  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
   assign w_mul_next = {w_mul_add, acc_q[XLEN-1:1]};

   // Restoring divide: remainder in the high half, dividend/quotient in the low half
   assign w_div_r    = acc_q[2*XLEN-1:XLEN-1];
   assign w_div_diff = w_div_r - {1'b0, opnd_q};
   assign w_div_next = w_div_diff[XLEN] ? {w_div_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                        : {w_div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   assign w_prod_fix = negres_q ? (-acc_q) : acc_q;
   assign w_quo_fix  = negres_q ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
   assign w_rem_fix  = negrem_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      w_fix_res = acc_q[XLEN-1:0];
      if (!special_q) begin
         case (op_q)
            3'd0:          w_fix_res = w_prod_fix[XLEN-1:0];
            3'd4, 3'd5:    w_fix_res = w_quo_fix;
            3'd6, 3'd7:    w_fix_res = w_rem_fix;
            default:       w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      negres_d  = negres_q;
      negrem_d  = negrem_q;
      special_d = special_q;
      result_d  = result_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               op_d      = req_op_i;
               negres_d  = w_sa ^ w_sb;
               negrem_d  = w_sa;
               special_d = w_special;
               cnt_d     = CNT_W'(XLEN);
               if (w_special) begin
                  acc_d   = {{XLEN{1'b0}}, w_special_res};
                  state_d = S_FIX;
               end else if (req_op_i[2]) begin
                  acc_d   = {{XLEN{1'b0}}, w_abs_a};
                  opnd_d  = w_abs_b;
                  state_d = S_CALC;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, w_abs_b};
                  opnd_d  = w_abs_a;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            acc_d = op_q[2] ? w_div_next : w_mul_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            result_d = w_fix_res;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (resp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         negres_q  <= 1'b0;
         negrem_q  <= 1'b0;
         special_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         negres_q  <= negres_d;
         negrem_q  <= negrem_d;
         special_q <= special_d;
         result_q  <= result_d;
      end
   end

   assign req_ready_o   = (state_q == S_IDLE);
   assign resp_valid_o  = (state_q == S_DONE);
   assign busy_o        = (state_q != S_IDLE);
   assign resp_result_o = result_q;

endmodule
`default_nettype wire
